counter_sequencer: RTL and testbench

//  Sequences the ring counters feeding the convolution datapath: pixel mux (8), kernel mux (3),

---
 rtl/counter_sequencer_if.sv | 30 +++
 rtl/counter_sequencer.sv | 125 ++++++++++++
 tb/tb_counter_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/counter_sequencer_if.sv
// Control bundle between the top-level FSM (master) and the counter sequencer (slave).
interface counter_sequencer_if;
    logic       start_s1;
    logic       abort_s1;
    logic       ready_s1;
    logic       busy_s1;
    logic       done_s1;
    logic       ctr_reset_s1;
    logic       pix_step_s1;
    logic       kern_step_s1;
    logic       word_step_s1;
    logic       mem_step_s1;
    logic [2:0] pix_idx_s1;
    logic [1:0] kern_idx_s1;
    logic [3:0] row_idx_s1;

    modport master (
        output start_s1, abort_s1, ready_s1,
        input  busy_s1, done_s1, ctr_reset_s1,
        input  pix_step_s1, kern_step_s1, word_step_s1, mem_step_s1,
        input  pix_idx_s1, kern_idx_s1, row_idx_s1
    );

    modport slave (
        input  start_s1, abort_s1, ready_s1,
        output busy_s1, done_s1, ctr_reset_s1,
        output pix_step_s1, kern_step_s1, word_step_s1, mem_step_s1,
        output pix_idx_s1, kern_idx_s1, row_idx_s1
    );
endinterface

// File: rtl/counter_sequencer.sv
// Frame-pass sequencer emitting step enables for the pixel/kernel/wordline/memory ring counters.
// Optional COUNTER_SEQ_AUTORESTART_EN: DONE goes straight to CLEAR when start_s1 is high.
module counter_sequencer #(
    parameter int unsigned PIX_COUNT  = 8,
    parameter int unsigned KERN_COUNT = 3,
    parameter int unsigned ROW_COUNT  = 9
) (
    input  logic                 Phi1,
    input  logic                 Reset_s1,
    counter_sequencer_if.slave   ctl
);
    localparam int unsigned PIX_W  = 3;
    localparam int unsigned KERN_W = 2;
    localparam int unsigned ROW_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [PIX_W-1:0]   r_pix_idx, w_pix_nxt;
    logic [KERN_W-1:0]  r_kern_idx, w_kern_nxt;
    logic [ROW_W-1:0]   r_row_idx, w_row_nxt;
    logic               r_busy, r_done, r_ctr_reset;
    logic               w_pix_step, w_kern_step, w_word_step;
    logic               w_pix_last, w_kern_last, w_row_last;

    assign w_pix_last  = (r_pix_idx  == PIX_W'(PIX_COUNT - 1));
    assign w_kern_last = (r_kern_idx == KERN_W'(KERN_COUNT - 1));
    assign w_row_last  = (r_row_idx  == ROW_W'(ROW_COUNT - 1));

    // State register; busy/done/ctr_reset are flopped decodes of the next state.
    always_ff @(posedge Phi1) begin
        if (Reset_s1) begin
            r_state     <= S_IDLE;
            r_pix_idx   <= '0;
            r_kern_idx  <= '0;
            r_row_idx   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ctr_reset <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pix_idx   <= w_pix_nxt;
            r_kern_idx  <= w_kern_nxt;
            r_row_idx   <= w_row_nxt;
            r_busy      <= (w_state_nxt == S_CLEAR) || (w_state_nxt == S_RUN);
            r_done      <= (w_state_nxt == S_DONE);
            r_ctr_reset <= (w_state_nxt == S_CLEAR);
        end
    end

    // Next-state, index advance and zero-latency step enables.
    always_comb begin
        w_state_nxt = r_state;
        w_pix_nxt   = r_pix_idx;
        w_kern_nxt  = r_kern_idx;
        w_row_nxt   = r_row_idx;
        w_pix_step  = 1'b0;
        w_kern_step = 1'b0;
        w_word_step = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (ctl.start_s1) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                w_state_nxt = ctl.abort_s1 ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (ctl.ready_s1) begin
                    w_pix_step = 1'b1;
                    if (w_pix_last) begin
                        w_pix_nxt   = '0;
                        w_kern_step = 1'b1;
                        if (w_kern_last) begin
                            w_kern_nxt  = '0;
                            w_word_step = 1'b1;
                            if (w_row_last) begin
                                w_row_nxt   = '0;
                                w_state_nxt = S_DONE;
                            end else begin
                                w_row_nxt = r_row_idx + ROW_W'(1);
                            end
                        end else begin
                            w_kern_nxt = r_kern_idx + KERN_W'(1);
                        end
                    end else begin
                        w_pix_nxt = r_pix_idx + PIX_W'(1);
                    end
                end
                // Abort overrides completion; steps already issued this cycle still stand.
                if (ctl.abort_s1) w_state_nxt = S_IDLE;
            end
            S_DONE: begin
`ifdef COUNTER_SEQ_AUTORESTART_EN
                w_state_nxt = ctl.start_s1 ? S_CLEAR : S_IDLE;
`else
                w_state_nxt = S_IDLE;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_state_nxt == S_CLEAR) begin
            w_pix_nxt  = '0;
            w_kern_nxt = '0;
            w_row_nxt  = '0;
        end
    end

    assign ctl.busy_s1      = r_busy;
    assign ctl.done_s1      = r_done;
    assign ctl.ctr_reset_s1 = r_ctr_reset;
    assign ctl.pix_step_s1  = w_pix_step;
    assign ctl.kern_step_s1 = w_kern_step;
    assign ctl.word_step_s1 = w_word_step;
    assign ctl.mem_step_s1  = w_word_step;
    assign ctl.pix_idx_s1   = r_pix_idx;
    assign ctl.kern_idx_s1  = r_kern_idx;
    assign ctl.row_idx_s1   = r_row_idx;
endmodule

// File: tb/tb_counter_sequencer.sv
// Testbench for counter_sequencer: directed scenarios plus random traffic against a pass-level model.
module tb_counter_sequencer;
    localparam int PIX  = 8;
    localparam int KERN = 3;
    localparam int ROW  = 9;
    localparam int TOTAL = PIX * KERN * ROW;

    logic Phi1;
    logic Reset_s1;
    counter_sequencer_if bus();

    counter_sequencer dut (.Phi1(Phi1), .Reset_s1(Reset_s1), .ctl(bus));

    initial Phi1 = 1'b0;
    always #5 Phi1 = ~Phi1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cyc    = 0;
    int t0       = 0;

    // Model: phase 0=idle 1=clear 2=run 3=done; m_k = pixel steps taken this pass.
    int m_phase = 0;
    int m_k     = 0;
    bit m_known = 1'b1;

    int obs_pix, obs_kern, obs_word, obs_mem, obs_clr_rel;
    int done_rel[$];

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, n_cyc);
        end
    endtask

    task automatic clear_obs();
        obs_pix = 0; obs_kern = 0; obs_word = 0; obs_mem = 0; obs_clr_rel = -1;
        done_rel.delete();
        t0 = n_cyc;
    endtask

    // One clock: drive inputs, check outputs before the edge, then advance the model.
    task automatic cyc(input bit rst, input bit st, input bit ab, input bit rdy);
        bit run_step;
        @(negedge Phi1);
        Reset_s1 = rst; bus.start_s1 = st; bus.abort_s1 = ab; bus.ready_s1 = rdy;
        #1;
        run_step = (m_phase == 2) && rdy;
        check_val("busy",      int'(bus.busy_s1),      int'(m_phase == 1 || m_phase == 2));
        check_val("done",      int'(bus.done_s1),      int'(m_phase == 3));
        check_val("ctr_reset", int'(bus.ctr_reset_s1), int'(m_phase == 1));
        check_val("pix_step",  int'(bus.pix_step_s1),  int'(run_step));
        check_val("kern_step", int'(bus.kern_step_s1), int'(run_step && (m_k % PIX == PIX - 1)));
        check_val("word_step", int'(bus.word_step_s1), int'(run_step && (m_k % (PIX*KERN) == PIX*KERN - 1)));
        check_val("mem_step",  int'(bus.mem_step_s1),  int'(run_step && (m_k % (PIX*KERN) == PIX*KERN - 1)));
        if (m_known) begin
            check_val("pix_idx",  int'(bus.pix_idx_s1),  m_k % PIX);
            check_val("kern_idx", int'(bus.kern_idx_s1), (m_k / PIX) % KERN);
            check_val("row_idx",  int'(bus.row_idx_s1),  m_k / (PIX*KERN));
        end
        obs_pix  += int'(bus.pix_step_s1);
        obs_kern += int'(bus.kern_step_s1);
        obs_word += int'(bus.word_step_s1);
        obs_mem  += int'(bus.mem_step_s1);
        if (bus.ctr_reset_s1 && obs_clr_rel < 0) obs_clr_rel = n_cyc - t0;
        if (bus.done_s1) done_rel.push_back(n_cyc - t0);
        @(posedge Phi1);
        n_cyc++;
        if (rst) begin
            m_phase = 0; m_k = 0; m_known = 1'b1;
        end else begin
            case (m_phase)
                0: if (st) begin m_phase = 1; m_k = 0; m_known = 1'b1; end
                1: m_phase = ab ? 0 : 2;
                2: begin
                    if (rdy) m_k++;
                    if (ab) begin
                        m_phase = 0; m_known = 1'b0;
                    end else if (m_k == TOTAL) begin
                        m_phase = 3; m_k = 0;
                    end
                end
                default: begin
`ifdef COUNTER_SEQ_AUTORESTART_EN
                    if (st) begin m_phase = 1; m_k = 0; m_known = 1'b1; end
                    else m_phase = 0;
`else
                    m_phase = 0;
`endif
                end
            endcase
        end
    endtask

    // Start a pass and run (ready high) until m_k reaches target in RUN.
    task automatic start_and_run_to(input int target);
        int guard = 0;
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        while (!(m_phase == 2 && m_k == target) && guard < 400) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            guard++;
        end
        check_val("reach_target_timeout", int'(guard < 400), 1);
    endtask

    task automatic full_pass_check(input string tag);
        clear_obs();
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (219) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check_val({tag, "_clr_cycle"}, obs_clr_rel, 1);
        check_val({tag, "_pix_steps"}, obs_pix, TOTAL);
        check_val({tag, "_kern_steps"}, obs_kern, KERN * ROW);
        check_val({tag, "_word_steps"}, obs_word, ROW);
        check_val({tag, "_mem_steps"}, obs_mem, ROW);
        check_val({tag, "_done_count"}, done_rel.size(), 1);
        check_val({tag, "_done_cycle"}, (done_rel.size() > 0) ? done_rel[0] : -1, 218);
    endtask

    initial begin
        Reset_s1 = 1'b1; bus.start_s1 = 1'b0; bus.abort_s1 = 1'b0; bus.ready_s1 = 1'b0;
        repeat (2) @(posedge Phi1);
        m_phase = 0; m_k = 0; m_known = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);

        full_pass_check("pass1");

        // Reset at pix=5, kern=1, row=3.
        start_and_run_to(3*PIX*KERN + 1*PIX + 5);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Stall at pix=7, kern=2, row=2, then resume.
        start_and_run_to(2*PIX*KERN + 1*PIX + 7 + PIX);
        clear_obs();
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("stall_no_steps", obs_pix + obs_kern + obs_word + obs_mem, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("resume_all_steps", obs_pix + obs_kern + obs_word + obs_mem, 4);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("resume_row", int'(bus.row_idx_s1), 3);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);

        // Abort at row 4, then a clean full pass.
        start_and_run_to(4*PIX*KERN);
        clear_obs();
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("abort_no_done", done_rel.size(), 0);
        full_pass_check("pass_after_abort");

        // Start held high throughout.
        clear_obs();
        repeat (440) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        check_val("held_done1", (done_rel.size() > 0) ? done_rel[0] : -1, 218);
`ifdef COUNTER_SEQ_AUTORESTART_EN
        check_val("held_done2", (done_rel.size() > 1) ? done_rel[1] : -1, 436);
`else
        check_val("held_done2", (done_rel.size() > 1) ? done_rel[1] : -1, 437);
`endif
        cyc(1'b1, 1'b0, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(999) == 0), ($urandom_range(7) == 0),
                ($urandom_range(299) == 0), ($urandom_range(4) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
